// File: rtl/game_pkg.sv
// game_pkg: shared state encoding and serve-direction constants for the pong match controller.
package game_pkg;
  typedef enum logic [2:0] {IDLE, SERVE, PLAY, POINT, GAME_OVER} game_state_t;
  localparam logic SERVE_TO_PLAYER = 1'b0;
  localparam logic SERVE_TO_ENEMY  = 1'b1;
  function automatic int max_int(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/frame_timer.sv
// frame_timer: loadable down-counter of frame ticks; done_o marks the tick that reaches zero.
module frame_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             tick_i,
  output logic             done_o
);
  logic [WIDTH-1:0] r_cnt;
  always_ff @(posedge clk_i) begin
    if (!rst_i) r_cnt <= '0;
    else if (load_i) r_cnt <= load_val_i;
    else if (tick_i && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
  end
  assign done_o = tick_i && !load_i && r_cnt == WIDTH'(1);
endmodule

// File: rtl/game_sequencer.sv
// game_sequencer: pong match FSM (serve, play, point pause, game over) with scores and winner.
// Define GAME_SEQ_AUTO_SERVE_EN to release the ball on serve-timer expiry instead of waiting for start.
module game_sequencer
  import game_pkg::*;
#(
  parameter int SCORE_W            = 4,
  parameter int WIN_SCORE          = 7,
  parameter int SERVE_DELAY_FRAMES = 60,
  parameter int POINT_PAUSE_FRAMES = 90
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               new_frame_i,
  input  logic               player_miss_i,
  input  logic               enemy_miss_i,
  output logic               ball_run_o,
  output logic               ball_reset_o,
  output logic               serve_dir_o,
  output logic [SCORE_W-1:0] player_score_o,
  output logic [SCORE_W-1:0] enemy_score_o,
  output logic               game_over_o,
  output logic               winner_o
);
  localparam int TW = $clog2(max_int(SERVE_DELAY_FRAMES, POINT_PAUSE_FRAMES) + 1);
  localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WIN_SCORE);
  if (WIN_SCORE < 1 || WIN_SCORE >= 2**SCORE_W || SERVE_DELAY_FRAMES < 1 || POINT_PAUSE_FRAMES < 1)
    begin : g_bad_param
      $error("game_sequencer: illegal parameter combination");
    end
  game_state_t        r_state;
  logic               r_start_q;
  logic               r_run;
  logic               r_ball_reset;
  logic               r_point_load;
  logic               r_dir;
  logic [SCORE_W-1:0] r_pscore;
  logic [SCORE_W-1:0] r_escore;
  logic               r_over;
  logic               r_winner;
  logic               w_start_rise;
  logic               w_done;
  logic [TW-1:0]      w_load_val;
`ifndef GAME_SEQ_AUTO_SERVE_EN
  logic               r_expired;
`endif
  assign w_start_rise = start_i && !r_start_q;
  // the load pulse lands on the first cycle of SERVE/POINT, so the state already selects the value
  assign w_load_val = r_state == SERVE ? TW'(SERVE_DELAY_FRAMES) : TW'(POINT_PAUSE_FRAMES);
  frame_timer #(.WIDTH(TW)) u_timer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (r_ball_reset || r_point_load),
    .load_val_i (w_load_val),
    .tick_i     (new_frame_i),
    .done_o     (w_done)
  );
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state      <= IDLE;
      r_start_q    <= 1'b1;
      r_run        <= 1'b0;
      r_ball_reset <= 1'b0;
      r_point_load <= 1'b0;
      r_dir        <= SERVE_TO_PLAYER;
      r_pscore     <= '0;
      r_escore     <= '0;
      r_over       <= 1'b0;
      r_winner     <= 1'b0;
`ifndef GAME_SEQ_AUTO_SERVE_EN
      r_expired    <= 1'b0;
`endif
    end else begin
      r_start_q    <= start_i;
      r_ball_reset <= 1'b0;
      r_point_load <= 1'b0;
`ifndef GAME_SEQ_AUTO_SERVE_EN
      if (r_state != SERVE) r_expired <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          r_pscore <= '0;
          r_escore <= '0;
          r_dir    <= SERVE_TO_PLAYER;
          if (w_start_rise) begin
            r_state      <= SERVE;
            r_ball_reset <= 1'b1;
          end
        end
        SERVE: begin
`ifdef GAME_SEQ_AUTO_SERVE_EN
          if (w_done) begin
            r_state <= PLAY;
            r_run   <= 1'b1;
          end
`else
          if (w_done) r_expired <= 1'b1;
          else if (r_expired && w_start_rise) begin
            r_state <= PLAY;
            r_run   <= 1'b1;
          end
`endif
        end
        PLAY: begin
          if (player_miss_i || enemy_miss_i) begin
            r_state      <= POINT;
            r_run        <= 1'b0;
            r_point_load <= 1'b1;
            if (player_miss_i && !enemy_miss_i) begin
              r_escore <= r_escore + 1'b1;
              r_dir    <= SERVE_TO_PLAYER;
            end else if (enemy_miss_i && !player_miss_i) begin
              r_pscore <= r_pscore + 1'b1;
              r_dir    <= SERVE_TO_ENEMY;
            end
          end
        end
        POINT: begin
          if (w_done && (r_pscore == WIN || r_escore == WIN)) begin
            r_state  <= GAME_OVER;
            r_over   <= 1'b1;
            r_winner <= r_escore == WIN;
          end else if (w_done) begin
            r_state      <= SERVE;
            r_ball_reset <= 1'b1;
          end
        end
        GAME_OVER: begin
          if (w_start_rise) begin
            r_state      <= SERVE;
            r_ball_reset <= 1'b1;
            r_pscore     <= '0;
            r_escore     <= '0;
            r_dir        <= SERVE_TO_PLAYER;
            r_over       <= 1'b0;
            r_winner     <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign ball_run_o     = r_run;
  assign ball_reset_o   = r_ball_reset;
  assign serve_dir_o    = r_dir;
  assign player_score_o = r_pscore;
  assign enemy_score_o  = r_escore;
  assign game_over_o    = r_over;
  assign winner_o       = r_winner;
endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: random match stimulus; a transaction-level model queues every expected output change.
module tb_game_sequencer;
  localparam int SW = 4, WIN = 7, SD = 60, PP = 90;
  logic clk = 0, rst = 0, start = 0, frame = 0, pmiss = 0, emiss = 0;
  logic run, brst, dir, over, win;
  logic [SW-1:0] ps, es;
  game_sequencer #(.SCORE_W(SW), .WIN_SCORE(WIN), .SERVE_DELAY_FRAMES(SD), .POINT_PAUSE_FRAMES(PP)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .new_frame_i(frame),
    .player_miss_i(pmiss), .enemy_miss_i(emiss),
    .ball_run_o(run), .ball_reset_o(brst), .serve_dir_o(dir),
    .player_score_o(ps), .enemy_score_o(es), .game_over_o(over), .winner_o(win)
  );
  always #5 clk = ~clk;
  typedef struct {int stamp; logic [12:0] v;} exp_t;
  exp_t sb[$];
  exp_t cur;
  int cyc = 0, n_chk = 0, n_fail = 0;
  bit mon_en = 0;
  logic [12:0] vec, prev;
  int m_ps = 0, m_es = 0;
  logic m_run = 0, m_dir = 0, m_over = 0, m_win = 0;
  assign vec = {run, brst, dir, ps, es, over, win};
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (mon_en && vec !== prev) begin
      n_chk++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_change cyc=%0d got=%h required=no change", cyc, vec);
      end else begin
        cur = sb.pop_front();
        if (cur.v !== vec || cur.stamp != cyc) begin
          n_fail++;
          $display("FAIL output_change got=%h at cyc %0d required=%h at cyc %0d", vec, cyc, cur.v, cur.stamp);
        end
      end
    end
    prev = vec;
  end
  function automatic logic rb(input int den);
    return $urandom_range(0, den - 1) == 0;
  endfunction
  function automatic void expect_next(input logic p);
    exp_t e;
    e.stamp = cyc + 1;
    e.v = {m_run, p, m_dir, 4'(m_ps), 4'(m_es), m_over, m_win};
    sb.push_back(e);
  endfunction
  task automatic check(input string nm, input int got, input int req);
    n_chk++;
    if (got != req) begin
      n_fail++;
      $display("FAIL %s got=%0d required=%0d", nm, got, req);
    end
  endtask
  task automatic step(input logic f, input logic pm, input logic em, input logic st);
    frame = f; pmiss = pm; emiss = em; start = st;
    @(negedge clk);
  endtask
  task automatic do_serve();
    int n = 0;
    logic f, st;
    expect_next(0);
    step(rb(2), rb(8), rb(8), 0);
    while (n < SD) begin
      f = rb(2);
      st = !start && !(f && n == SD - 1) && rb(10);
      if (f) n++;
`ifdef GAME_SEQ_AUTO_SERVE_EN
      if (f && n == SD) begin m_run = 1; expect_next(0); end
`endif
      step(f, rb(8), rb(8), st);
    end
`ifndef GAME_SEQ_AUTO_SERVE_EN
    repeat ($urandom_range(1, 6)) step(rb(2), rb(8), rb(8), 0);
    m_run = 1;
    expect_next(0);
    step(rb(2), 0, 0, 1);
`endif
  endtask
  task automatic play_point(input int kind);
    int n = 0;
    logic f, st;
    repeat ($urandom_range(0, 4)) step(rb(2), 0, 0, !start && rb(3));
    m_run = 0;
    if (kind == 0) begin m_es++; m_dir = 0; end
    else if (kind == 1) begin m_ps++; m_dir = 1; end
    expect_next(0);
    step(rb(2), kind != 1, kind != 0, 0);
    step(rb(2), rb(8), rb(8), !start && rb(3));
    while (n < PP) begin
      f = rb(2);
      st = !start && !(f && n == PP - 1) && rb(6);
      if (f) n++;
      if (f && n == PP) begin
        if (m_ps == WIN || m_es == WIN) begin
          m_over = 1; m_win = m_es == WIN; expect_next(0);
        end else expect_next(1);
      end
      step(f, rb(8), rb(8), st);
    end
    if (!m_over) do_serve();
  endtask
  task automatic restart();
    m_ps = 0; m_es = 0; m_dir = 0; m_over = 0; m_win = 0; m_run = 0;
    expect_next(1);
    step(rb(2), rb(2), rb(2), 1);
    do_serve();
  endtask
  initial begin
    int k[6] = '{1, 1, 1, 0, 0, 2};
    int j, t;
    repeat (3) @(negedge clk);
    check("reset_run", run, 0); check("reset_ball_reset", brst, 0); check("reset_dir", dir, 0);
    check("reset_pscore", ps, 0); check("reset_escore", es, 0); check("reset_over", over, 0);
    check("reset_winner", win, 0);
    mon_en = 1;
    rst = 1;
    step(0, 0, 0, 0);
    restart();
    for (int i = 5; i > 0; i--) begin
      j = $urandom_range(0, i); t = k[i]; k[i] = k[j]; k[j] = t;
    end
    foreach (k[i]) play_point(k[i]);
    check("mid_pscore", ps, 3); check("mid_escore", es, 2); check("mid_run", run, 1);
    m_ps = 0; m_es = 0; m_dir = 0; m_run = 0;
    expect_next(0);
    rst = 0;
    step(rb(2), rb(4), rb(4), 1);
    rst = 1;
    repeat (6) step(rb(2), rb(4), rb(4), 1);
    check("held_key_no_restart_reset", brst, 0); check("held_key_no_restart_run", run, 0);
    step(0, 0, 0, 0);
    restart();
    while (m_ps < WIN && m_es < WIN) play_point($urandom_range(0, 2));
    check("g2_over", over, 1); check("g2_winner", win, int'(m_es == WIN));
    repeat (12) step(rb(2), rb(2), rb(2), 0);
    restart();
    repeat (WIN) play_point(0);
    check("g3_over", over, 1); check("g3_winner", win, 1); check("g3_escore", es, WIN);
    repeat (12) step(rb(2), rb(2), rb(2), 0);
    restart();
    repeat (4) step(0, 0, 0, 0);
    check("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog timeout cyc=%0d required=finish", cyc);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/game_sequencer.md
# game_sequencer

Match-level controller for the pong core. Sits between the board inputs and `game_logic`. Sequences each rally through serve, play, point pause and game over, and gates ball motion through enable and re-centre controls. Keeps both scores and decides the winner. All timing is counted in frames, using the per-frame pulse from `game_display`.

## Interface
Parameters:
- `SCORE_W`, 4: score counter width.
- `WIN_SCORE`, 7: points needed to win. Must satisfy 1 ≤ WIN_SCORE < 2**SCORE_W; an elaboration-time check enforces this.
- `SERVE_DELAY_FRAMES`, 60: frames between ball re-centre and ball release. Must be ≥ 1.
- `POINT_PAUSE_FRAMES`, 90: frames of freeze after a point. Must be ≥ 1.

Ports:
- `clk_i`, in, 1: system clock. Single clock domain.
- `rst_i`, in, 1: reset, synchronous, active-low.
- `start_i`, in, 1: start/serve key, level. Rising edge is detected internally.
- `new_frame_i`, in, 1: one-cycle pulse per video frame.
- `player_miss_i`, in, 1: one-cycle pulse, ball passed the player paddle.
- `enemy_miss_i`, in, 1: one-cycle pulse, ball passed the computer paddle.
- `ball_run_o`, out, 1: ball motion enable to `game_logic`.
- `ball_reset_o`, out, 1: one-cycle pulse, re-centre ball.
- `serve_dir_o`, out, 1: initial ball direction. 0 = toward player, 1 = toward computer.
- `player_score_o`, out, `SCORE_W`: player points.
- `enemy_score_o`, out, `SCORE_W`: computer points.
- `game_over_o`, out, 1: high while in GAME_OVER.
- `winner_o`, out, 1: valid while `game_over_o` is high. 0 = player won, 1 = computer won.

## Operation
- States are IDLE, SERVE, PLAY, POINT and GAME_OVER.
- Edge detection: `start_rise = start_i & ~start_q`. `start_q` is registered and resets to 1, so a key held through reset does not start a game.
- **IDLE**
  - On `start_rise`, go to SERVE.
  - Clear both scores.
  - Set `serve_dir_o = 0`.
- **SERVE**
  - On entry: pulse `ball_reset_o` and load the frame timer with `SERVE_DELAY_FRAMES`.
  - Each `new_frame_i` decrements the timer.
  - The timer expires on the pulse that takes it to 0.
- **PLAY**
  - `ball_run_o = 1`.
  - `player_miss_i` alone: increment the enemy score, set `serve_dir_o = 0`, go to POINT.
  - `enemy_miss_i` alone: increment the player score, set `serve_dir_o = 1`, go to POINT.
  - Both misses in the same cycle: no score change, `serve_dir_o` unchanged, go to POINT.
- **POINT**
  - On entry, load the timer with `POINT_PAUSE_FRAMES`.
  - On expiry, go to GAME_OVER if either score equals `WIN_SCORE`, otherwise go to SERVE.
- **GAME_OVER**
  - `game_over_o = 1`. `winner_o = 1` iff the enemy score equals `WIN_SCORE`.
  - On `start_rise`: clear scores, set `serve_dir_o = 0`, go to SERVE.
- Misses are ignored in every state except PLAY.
- `start_rise` is ignored in SERVE (unless the configuration macro below is absent), PLAY and POINT.
- Scores never exceed `WIN_SCORE`: the game ends before another increment can occur.

## Timing
- Reset values: state IDLE, `ball_run_o = 0`, `ball_reset_o = 0`, `serve_dir_o = 0`, both scores 0, `game_over_o = 0`, `winner_o = 0`.
- All outputs are registered and reflect the current state one cycle after the transition edge.
- `ball_reset_o` is high for exactly one cycle: the first cycle in SERVE.
- Release latency: `ball_run_o` rises 1 cycle after the `SERVE_DELAY_FRAMES`-th `new_frame_i` pulse counted in SERVE.
- Stop latency: a miss pulse at cycle N gives `ball_run_o = 0` and the updated score at cycle N+1.
- A `new_frame_i` pulse in the same cycle as state entry is not counted; the timer load takes priority.
- `rst_i` low in any cycle, in any state, forces the reset values at the next edge. The timer is cleared.

## Configuration
- `GAME_SEQ_AUTO_SERVE_EN` defined: SERVE goes to PLAY on timer expiry.
- Undefined: after expiry the FSM stays in SERVE with `ball_run_o = 0` until `start_rise`, then goes to PLAY on the next edge. A `start_rise` before expiry is ignored.

## Structure
- Package `game_pkg` holds:
  - `typedef enum logic [2:0] game_state_t` for the five states.
  - Constants `SERVE_TO_PLAYER = 1'b0` and `SERVE_TO_ENEMY = 1'b1`.
- Sub-module `frame_timer`:
  - Parameter `WIDTH`.
  - Ports: `load_i`, `load_val_i`, `tick_i` (driven by `new_frame_i`), `done_o` (one-cycle pulse on reaching 0).
  - Load beats tick.
- Timer width is `$clog2(max(SERVE_DELAY_FRAMES, POINT_PAUSE_FRAMES) + 1)`.

## Test plan
- Reset, then `start_i` pulse:
  - `ball_reset_o` high for 1 cycle.
  - After 60 `new_frame_i` pulses, `ball_run_o = 1` one cycle later; not earlier.
- PLAY, `enemy_miss_i` pulse:
  - Next cycle: `player_score_o = 1`, `ball_run_o = 0`, `serve_dir_o = 1`.
  - After 90 frames, `ball_reset_o` pulses.
- PLAY, `player_miss_i` and `enemy_miss_i` in the same cycle: scores unchanged, state POINT, then SERVE after 90 frames.
- Drive 7 enemy points:
  - After the 7th pause, `game_over_o = 1` and `winner_o = 1`.
  - Further misses are ignored.
  - `start_i` edge clears scores and `ball_reset_o` pulses.
- `rst_i = 0` for 1 cycle mid-PLAY with score 3–2: next cycle all outputs are at reset values and state is IDLE. Hold `start_i = 1` across the reset: no restart until the key is released and pressed again.
- Build without `GAME_SEQ_AUTO_SERVE_EN`:
  - `ball_run_o` stays 0 after 60 frames.
  - A `start_i` edge releases it one cycle later.
  - A `start_i` edge before expiry is ignored.
